// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   - opcode encodings that also serve as the ALU result-mux select
//   - FSM state encoding
package alu_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;  // result = A
    localparam logic [1:0] OP_ADD  = 2'b01;  // result = A + B (wraps)
    localparam logic [1:0] OP_AND  = 2'b10;  // result = A & B
    localparam logic [1:0] OP_NOT  = 2'b11;  // result = ~A

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETTLE  = 2'b01,
        ST_CAPTURE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Accepts one command per valid/ready handshake, drives the ALU mux select and
//   operand A, holds them for SETTLE_CYCLES clocks while the external combinational
//   ALU settles, then captures the ALU result into the accumulator. The accumulator
//   is fed back as operand B so commands chain.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cmd_valid    in   command present on cmd_op / cmd_operand
//   cmd_ready    out  sequencer can accept a command this cycle
//   cmd_op       in   opcode (see alu_pkg)
//   cmd_operand  in   operand, becomes ALU operand A
//   alu_control  out  ALU result-mux select
//   alu_a        out  ALU operand A
//   alu_b        out  ALU operand B (accumulator)
//   alu_result   in   ALU result, combinational from alu_control/alu_a/alu_b
//   acc          out  accumulator
//   done         out  one-cycle pulse, acc updated this cycle
//   zero         out  acc == 0, registered alongside acc
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | ready for a command; select and operand A held from last one
// ST_SETTLE  | select/operands held while the ALU path settles
// ST_CAPTURE | ALU result sampled into acc, done pulses the next cycle
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic [1:0]       alu_control,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] acc,
    output logic             done,
    output logic             zero
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    seq_state_t       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        acc_d   = acc_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ready_q is low for the first cycle after reset, so no accept then
                if (cmd_valid && ready_q) begin
                    ctrl_d  = cmd_op;
                    a_d     = cmd_operand;
                    cnt_d   = SETTLE_LOAD;
                    state_d = (SETTLE_LOAD == 4'd0) ? ST_CAPTURE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // a count of 0 can't occur here; treated like 1 so the FSM can't stick
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                acc_d   = alu_result;
                zero_d  = (alu_result == '0);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // registered from the next state so cmd_ready depends on state only
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            ctrl_q  <= OP_LOAD;
            a_q     <= '0;
            acc_q   <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign alu_control = ctrl_q;
    assign alu_a       = a_q;
    assign alu_b       = acc_q;
    assign acc         = acc_q;
    assign done        = done_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DUT with SETTLE_CYCLES = 2
    logic       rst_n, cmd_valid, cmd_ready, done, zero;
    logic [1:0] cmd_op, alu_control;
    logic [7:0] cmd_operand, alu_a, alu_b, alu_result, acc;

    // DUT with SETTLE_CYCLES = 0
    logic       rst0_n, cmd_valid0, cmd_ready0, done0, zero0;
    logic [1:0] cmd_op0, alu_control0;
    logic [7:0] cmd_operand0, alu_a0, alu_b0, alu_result0, acc0;

    alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand), .alu_control(alu_control),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .acc(acc),
        .done(done), .zero(zero)
    );

    alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op0), .cmd_operand(cmd_operand0), .alu_control(alu_control0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_result(alu_result0), .acc(acc0),
        .done(done0), .zero(zero0)
    );

    // 4:1 result mux fed by adder / AND / NOT
    always_comb begin
        case (alu_control)
            OP_LOAD: alu_result = alu_a;
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            default: alu_result = ~alu_a;
        endcase
    end

    always_comb begin
        case (alu_control0)
            OP_LOAD: alu_result0 = alu_a0;
            OP_ADD:  alu_result0 = alu_a0 + alu_b0;
            OP_AND:  alu_result0 = alu_a0 & alu_b0;
            default: alu_result0 = ~alu_a0;
        endcase
    end

    // Drives a command (called at a negedge) and waits for the handshake edge.
    // Returns at the negedge right after the handshake edge.
    task automatic handshake(input bit sel, input logic [1:0] op, input logic [7:0] opnd,
                             input bit keep, output bit ok);
        ok = 1'b0;
        if (sel) begin
            cmd_valid0 = 1'b1; cmd_op0 = op; cmd_operand0 = opnd;
        end else begin
            cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd;
        end
        for (int i = 0; i < 20; i++) begin
            if ((sel ? cmd_ready0 : cmd_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (!keep) begin
            if (sel) cmd_valid0 = 1'b0;
            else     cmd_valid  = 1'b0;
        end
    endtask

    task automatic test_cmd(input string name, input logic [1:0] op, input logic [7:0] opnd,
                            input logic [7:0] exp_acc, input logic exp_zero);
        bit ok;
        int k;
        handshake(1'b0, op, opnd, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s handshake: cmd_ready never seen within bound", name);
        end
        k = 0;
        while (done !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL %s latency: got %0d clks expected 3", name, k);
        end
        checks++;
        if (acc !== exp_acc) begin
            errors++;
            $display("FAIL %s acc: got %h expected %h", name, acc, exp_acc);
        end
        checks++;
        if (zero !== exp_zero) begin
            errors++;
            $display("FAIL %s zero: got %b expected %b", name, zero, exp_zero);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after: got %b expected 1", name, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width: got %b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst0_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_operand = 8'h00;
        cmd_valid0 = 1'b0; cmd_op0 = 2'b00; cmd_operand0 = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({acc, zero, done, cmd_ready, alu_control, alu_a} !== {8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got acc=%h zero=%b done=%b ready=%b ctrl=%b a=%h expected 00 1 0 0 00 00",
                     acc, zero, done, cmd_ready, alu_control, alu_a);
        end
        rst_n = 1'b1; rst0_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_hold_back_to_back();
        bit ok;
        int m;
        handshake(1'b0, OP_LOAD, 8'h3C, 1'b1, ok);
        cmd_op = OP_ADD; cmd_operand = 8'h01;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({cmd_ready, alu_control, alu_a} !== {1'b0, OP_LOAD, 8'h3C}) begin
                errors++;
                $display("FAIL hold_busy[%0d]: got ready=%b ctrl=%b a=%h expected 0 00 3c",
                         k, cmd_ready, alu_control, alu_a);
            end
            @(negedge clk);
        end
        checks++;
        if ({done, acc, cmd_ready, alu_control} !== {1'b1, 8'h3C, 1'b1, OP_LOAD}) begin
            errors++;
            $display("FAIL hold_first_done: got done=%b acc=%h ready=%b ctrl=%b expected 1 3c 1 00",
                     done, acc, cmd_ready, alu_control);
        end
        @(negedge clk);
        checks++;
        if ({alu_control, alu_a, cmd_ready, done} !== {OP_ADD, 8'h01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_take: got ctrl=%b a=%h ready=%b done=%b expected 01 01 0 0",
                     alu_control, alu_a, cmd_ready, done);
        end
        cmd_valid = 1'b0;
        m = 0;
        while (done !== 1'b1 && m < 10) begin
            @(negedge clk);
            m++;
        end
        checks++;
        if (m !== 3 || acc !== 8'h3D) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d acc=%h expected 3 3d", m, acc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_settle();
        bit ok;
        bit bad;
        handshake(1'b0, OP_LOAD, 8'h77, 1'b0, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({acc, zero, done, cmd_ready} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_settle: got acc=%h zero=%b done=%b ready=%b expected 00 1 0 0",
                     acc, zero, done, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || acc !== 8'h00) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_capture_after_reset: got done/acc activity expected none (acc=%h)", acc);
        end
    endtask

    task automatic test_settle0();
        bit ok;
        handshake(1'b1, OP_LOAD, 8'h01, 1'b0, ok);
        checks++;
        if ({ok, cmd_ready0, done0} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL s0_after_handshake: got ok=%b ready=%b done=%b expected 1 0 0",
                     ok, cmd_ready0, done0);
        end
        @(negedge clk);
        checks++;
        if ({acc0, done0, cmd_ready0, zero0} !== {8'h01, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL s0_capture: got acc=%h done=%b ready=%b zero=%b expected 01 1 1 0",
                     acc0, done0, cmd_ready0, zero0);
        end
    endtask

    initial begin
        test_reset();
        test_cmd("load_3c",   OP_LOAD, 8'h3C, 8'h3C, 1'b0);
        test_cmd("load_f0",   OP_LOAD, 8'hF0, 8'hF0, 1'b0);
        test_cmd("add_wrap",  OP_ADD,  8'h20, 8'h10, 1'b0);
        test_cmd("add_zero",  OP_ADD,  8'hF0, 8'h00, 1'b1);
        test_cmd("load_aa",   OP_LOAD, 8'hAA, 8'hAA, 1'b0);
        test_cmd("and_0f",    OP_AND,  8'h0F, 8'h0A, 1'b0);
        test_cmd("not_55",    OP_NOT,  8'h55, 8'hAA, 1'b0);
        test_hold_back_to_back();
        test_reset_mid_settle();
        test_settle0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
